// File: rtl/stream_pooler_if.sv
// Pixel stream into the pooler and pooled result stream out of it.
// The DUT uses the slave modport; the pixel source uses the master modport.
interface stream_pooler_if #(
  parameter int unsigned N = 16
) ();
  logic         ce;
  logic         mode;
  logic [N-1:0] data_in;
  logic [N-1:0] data_out;
  logic         valid_op;
  logic         end_op;

  modport master (
    output ce, mode, data_in,
    input  data_out, valid_op, end_op
  );

  modport slave (
    input  ce, mode, data_in,
    output data_out, valid_op, end_op
  );
endinterface

// File: rtl/stream_pooler.sv
// Streaming PxP non-overlapping max/average pooling over a raster-ordered MxM map.
// A row buffer holds per-window partial results so any M, P runs without stalls.
module stream_pooler #(
  parameter int unsigned N         = 16,
  parameter int unsigned Q         = 12,
  parameter int unsigned M         = 12,
  parameter int unsigned P         = 3,
  parameter int unsigned P_SQR_INV = 455
) (
  input logic            clk,
  input logic            master_rst,
  stream_pooler_if.slave io
);

  localparam int unsigned NB  = M / P;
  localparam int unsigned SW  = N + $clog2(P * P);
  localparam int unsigned PRW = SW + N;
  localparam int unsigned PW  = $clog2(P);
  localparam int unsigned WW  = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [PW-1:0] PLast = PW'(P - 1);
  localparam logic [WW-1:0] WLast = WW'(NB - 1);

  localparam logic signed [PRW-1:0] SatHi = {{(PRW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [PRW-1:0] SatLo = {{(PRW-N+1){1'b1}}, {(N-1){1'b0}}};

  if (M % P != 0) begin : g_bad_m
    $error("stream_pooler: M must be a multiple of P");
  end
  if (P < 2 || P > M) begin : g_bad_p
    $error("stream_pooler: P must satisfy 2 <= P <= M");
  end

  typedef logic signed [SW-1:0] acc_t;
  typedef enum logic [0:0] {StIdle, StRun} state_e;

  function automatic acc_t combine(acc_t a, acc_t b, logic is_max);
    if (is_max) return (a > b) ? a : b;
    return a + b;
  endfunction

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  // col/row kept split as (window index, offset within window) to avoid div/mod
  logic [PW-1:0] pc_q, pc_d, pr_q, pr_d;
  logic [WW-1:0] wc_q, wc_d, wr_q, wr_d;
  acc_t          acc_q, acc_d;
  logic [N-1:0]  data_out_q, data_out_d;
  logic          valid_q, valid_d, end_q, end_d;

  acc_t          row_buf_q [NB];
  logic          buf_we;
  acc_t          buf_wdata;

  logic                  mode_cur, frame_last;
  acc_t                  pix, acc_in, entry, final_v;
  logic signed [PRW-1:0] fin_ext, inv_ext, prod, scaled;
  logic [N-1:0]          avg_res;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pc_d       = pc_q;
    pr_d       = pr_q;
    wc_d       = wc_q;
    wr_d       = wr_q;
    acc_d      = acc_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    end_d      = 1'b0;
    buf_we     = 1'b0;
    buf_wdata  = '0;

    mode_cur   = (state_q == StIdle) ? io.mode : mode_q;
    pix        = acc_t'($signed(io.data_in));
    acc_in     = (pc_q == '0) ? pix : combine(acc_q, pix, mode_cur);
    entry      = row_buf_q[wc_q];
    final_v    = combine(entry, acc_in, mode_cur);
    frame_last = (pc_q == PLast) && (wc_q == WLast) && (pr_q == PLast) && (wr_q == WLast);

    // Average: multiply by round(2^Q/P^2), then floor-shift back to Q format.
    fin_ext = PRW'(final_v);
    inv_ext = PRW'(P_SQR_INV);
    prod    = fin_ext * inv_ext;
    scaled  = prod >>> Q;
    if (scaled > SatHi)      avg_res = SatHi[N-1:0];
    else if (scaled < SatLo) avg_res = SatLo[N-1:0];
    else                     avg_res = scaled[N-1:0];

    if (io.ce) begin
      state_d = frame_last ? StIdle : StRun;
      if (state_q == StIdle) mode_d = io.mode;
      acc_d = acc_in;

      if (pc_q == PLast) begin
        pc_d = '0;
        if (wc_q == WLast) begin
          wc_d = '0;
          if (pr_q == PLast) begin
            pr_d = '0;
            wr_d = (wr_q == WLast) ? '0 : wr_q + 1'b1;
          end else begin
            pr_d = pr_q + 1'b1;
          end
        end else begin
          wc_d = wc_q + 1'b1;
        end

        if (pr_q == '0) begin
          buf_we    = 1'b1;
          buf_wdata = acc_in;
        end else if (pr_q != PLast) begin
          buf_we    = 1'b1;
          buf_wdata = combine(acc_in, entry, mode_cur);
        end else begin
          valid_d    = 1'b1;
          data_out_d = mode_cur ? final_v[N-1:0] : avg_res;
          end_d      = (wc_q == WLast) && (wr_q == WLast);
        end
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      pc_q       <= '0;
      pr_q       <= '0;
      wc_q       <= '0;
      wr_q       <= '0;
      acc_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pc_q       <= pc_d;
      pr_q       <= pr_d;
      wc_q       <= wc_d;
      wr_q       <= wr_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      end_q      <= end_d;
    end
  end

  // Entries are always written on a window's first row before being read.
  always_ff @(posedge clk) begin
    if (buf_we) row_buf_q[wc_q] <= buf_wdata;
  end

  assign io.data_out = data_out_q;
  assign io.valid_op = valid_q;
  assign io.end_op   = end_q;

endmodule

// File: tb/tb_stream_pooler.sv
// Scoreboard bench for stream_pooler: stimulus pushes hand-computed results,
// per-DUT monitors pop and compare on every valid_op.
module tb_stream_pooler;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  logic master_rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t        exp_a[$];
  exp_t        exp_b[$];
  logic [15:0] vec_q[$];

  stream_pooler_if #(.N(16)) a_if ();
  stream_pooler_if #(.N(16)) b_if ();

  stream_pooler #(.N(16), .Q(12), .M(4), .P(2), .P_SQR_INV(1024)) dut_a (
    .clk        (clk),
    .master_rst (master_rst),
    .io         (a_if)
  );

  stream_pooler #(.N(16), .Q(12), .M(12), .P(3), .P_SQR_INV(455)) dut_b (
    .clk        (clk),
    .master_rst (master_rst),
    .io         (b_if)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int d, input logic ce, input logic m, input logic [15:0] v);
    if (d == 0) begin
      a_if.ce = ce; a_if.mode = m; a_if.data_in = v;
    end else begin
      b_if.ce = ce; b_if.mode = m; b_if.data_in = v;
    end
  endtask

  function automatic logic [15:0] pix_val(input int kind, input int idx, input int r, input int c);
    case (kind)
      0:       return 16'(idx);
      1:       return 16'h1000;
      2:       return 16'hF000;
      default: return ((r + c) % 2 == 1) ? 16'h7FFF : 16'h8000;
    endcase
  endfunction

  // Drives one frame; vec_q holds the expected results in window order.
  task automatic run_frame(input int d, input int mm, input int pp, input logic m,
                           input int kind, input bit stall, input bit toggle,
                           input int stop_at);
    int   k = 0;
    bit   force_idle = 1'b0;
    exp_t e;
    for (int idx = 0; idx < mm * mm; idx++) begin
      int r = idx / mm;
      int c = idx % mm;
      logic mm_now = (toggle && idx >= 3) ? ~m : m;
      if (stall && (force_idle || $urandom_range(0, 9) < 4)) begin
        set_px(d, 1'b0, mm_now, 16'h0);
        tick();
      end
      force_idle = 1'b0;
      set_px(d, 1'b1, mm_now, pix_val(kind, idx, r, c));
      if (idx == stop_at) return;
      if ((r % pp == pp - 1) && (c % pp == pp - 1)) begin
        e.d = vec_q[k];
        e.e = (idx == mm * mm - 1);
        e.c = cyc + 1;
        k++;
        if (d == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
        force_idle = 1'b1;
      end
      tick();
    end
  endtask

  always @(negedge clk) begin
    exp_t ea;
    if (a_if.valid_op) begin
      if (exp_a.size() == 0) chk("a_spurious_valid", 32'(a_if.valid_op), 32'd0);
      else begin
        ea = exp_a.pop_front();
        chk("a_data", 32'(a_if.data_out), 32'(ea.d));
        chk("a_end", 32'(a_if.end_op), 32'(ea.e));
        chk("a_latency_cycle", cyc, ea.c);
      end
    end else if (a_if.end_op) begin
      chk("a_end_without_valid", 32'(a_if.end_op), 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t eb;
    if (b_if.valid_op) begin
      if (exp_b.size() == 0) chk("b_spurious_valid", 32'(b_if.valid_op), 32'd0);
      else begin
        eb = exp_b.pop_front();
        chk("b_data", 32'(b_if.data_out), 32'(eb.d));
        chk("b_end", 32'(b_if.end_op), 32'(eb.e));
        chk("b_latency_cycle", cyc, eb.c);
      end
    end else if (b_if.end_op) begin
      chk("b_end_without_valid", 32'(b_if.end_op), 32'd0);
    end
  end

  initial begin
    set_px(0, 1'b0, 1'b0, 16'h0);
    set_px(1, 1'b0, 1'b0, 16'h0);
    repeat (2) tick();
    chk("rst_a_data_out", 32'(a_if.data_out), 32'd0);
    chk("rst_a_valid_op", 32'(a_if.valid_op), 32'd0);
    chk("rst_a_end_op", 32'(a_if.end_op), 32'd0);
    chk("rst_b_data_out", 32'(b_if.data_out), 32'd0);
    chk("rst_b_valid_op", 32'(b_if.valid_op), 32'd0);
    chk("rst_b_end_op", 32'(b_if.end_op), 32'd0);
    #2 master_rst = 1'b1;
    tick();

    // Max, 0..15 raw: window maxima are the bottom-right pixels
    vec_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    run_frame(0, 4, 2, 1'b1, 0, 1'b0, 1'b0, -1);
    // Average of +1.0 and -1.0 constant maps, back to back
    vec_q = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    run_frame(0, 4, 2, 1'b0, 1, 1'b0, 1'b0, -1);
    vec_q = '{16'hF000, 16'hF000, 16'hF000, 16'hF000};
    run_frame(0, 4, 2, 1'b0, 2, 1'b0, 1'b0, -1);
    set_px(0, 1'b0, 1'b0, 16'h0);
    tick();

    // Random stalls, including one right after every completing pixel
    vec_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    run_frame(0, 4, 2, 1'b1, 0, 1'b1, 1'b0, -1);
    set_px(0, 1'b0, 1'b0, 16'h0);
    tick();

    // Mode toggled mid-frame is ignored; avg of 0..15: 10/4, 18/4, 42/4, 50/4 floored
    vec_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    run_frame(0, 4, 2, 1'b1, 0, 1'b0, 1'b1, -1);
    vec_q = '{16'd2, 16'd4, 16'd10, 16'd12};
    run_frame(0, 4, 2, 1'b0, 0, 1'b0, 1'b1, -1);
    set_px(0, 1'b0, 1'b0, 16'h0);
    tick();

    // Defaults: 9 * 0x1000 * 455 >> 12 = 0x0FFF; max of 0x7FFF/0x8000 mix = 0x7FFF
    vec_q.delete();
    for (int i = 0; i < 16; i++) vec_q.push_back(16'h0FFF);
    run_frame(1, 12, 3, 1'b0, 1, 1'b0, 1'b0, -1);
    vec_q.delete();
    for (int i = 0; i < 16; i++) vec_q.push_back(16'h7FFF);
    run_frame(1, 12, 3, 1'b1, 3, 1'b0, 1'b0, -1);
    set_px(1, 1'b0, 1'b0, 16'h0);
    repeat (3) tick();

    // Asynchronous reset while pixel 9 is presented
    vec_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    run_frame(0, 4, 2, 1'b1, 0, 1'b0, 1'b0, 9);
    #2 master_rst = 1'b0;
    #1;
    chk("midrst_a_data_out", 32'(a_if.data_out), 32'd0);
    chk("midrst_a_valid_op", 32'(a_if.valid_op), 32'd0);
    chk("midrst_a_end_op", 32'(a_if.end_op), 32'd0);
    chk("midrst_b_data_out", 32'(b_if.data_out), 32'd0);
    set_px(0, 1'b0, 1'b1, 16'h0);
    tick();
    #2 master_rst = 1'b1;
    tick();
    chk("midrst_pending_a", exp_a.size(), 32'd0);
    exp_a.delete();

    vec_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    run_frame(0, 4, 2, 1'b1, 0, 1'b0, 1'b0, -1);
    set_px(0, 1'b0, 1'b0, 16'h0);
    repeat (4) tick();

    chk("drain_a", exp_a.size(), 32'd0);
    chk("drain_b", exp_b.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
